// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a
// data port. Data normally has priority; a streak counter bounds how many
// data grants in a row may pass a waiting fetch. Every access holds the
// memory for exactly LAT cycles, after which the matching ack is registered
// for one cycle together with the returned read data.
//
// Parameters
//   LAT     memory read latency in cycles (1..7)
//   STREAK  max consecutive data grants while a fetch waits (1..15)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ack) and byte address
//   if_ack/if_rdata          fetch completion pulse and fetched word (held)
//   d_req/d_we/d_addr        data request, write enable, byte address
//   d_wdata/d_sel            write data and byte-lane enables
//   d_ack/d_rdata            data completion pulse and read data (held)
//   mem_ce/mem_we            memory enable / write enable (0 outside an access)
//   mem_addr/mem_wdata/sel   memory address, write data, lane enables
//   mem_rdata                memory read data, sampled on the last access edge
//   stall_req                pipeline stall while any request is unserved
//
// A fetch drives mem_sel=4'hF (full word) and mem_wdata=0 while it runs.
module mem_arbiter #(
  parameter int unsigned LAT    = 1,
  parameter int unsigned STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  input  logic [31:0] mem_rdata,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    IDLE,
    IF_ACC,
    D_ACC
  } state_t;

  localparam logic [2:0] ACC_LAST   = 3'(LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(STREAK);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  acc_cnt;
  logic [3:0]  streak;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_sel;

  logic        if_pend;
  logic        d_pend;
  logic        grant_if;
  logic        grant_d;
  logic        acc_last;

  // In the ack cycle the requester still shows the request it has just had
  // served; masking with the ack keeps it out of arbitration and the stall.
  assign if_pend   = if_req & ~if_ack;
  assign d_pend    = d_req & ~d_ack;
  assign stall_req = if_pend | d_pend;
  assign acc_last  = (acc_cnt == ACC_LAST);

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_pend && !(if_pend && (streak == STREAK_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = D_ACC;
        end else if (if_pend) begin
          grant_if  = 1'b1;
          state_nxt = IF_ACC;
        end
      end
      IF_ACC, D_ACC: begin
        if (acc_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sel   = '0;
    if (state != IDLE) begin
      mem_ce    = 1'b1;
      mem_we    = lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_sel   = lat_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      streak    <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_sel   <= '0;
    end else begin
      state  <= state_nxt;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      if (grant_d) begin
        lat_we    <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
        lat_sel   <= d_sel;
        if (if_pend)
          streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
        else
          streak <= '0;
      end

      if (grant_if) begin
        lat_we    <= 1'b0;
        lat_addr  <= if_addr;
        lat_wdata <= '0;
        lat_sel   <= 4'hF;
        streak    <= '0;
      end

      if (state != IDLE) begin
        if (acc_last) begin
          acc_cnt <= '0;
          if (state == IF_ACC) begin
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end else begin
            d_ack <= 1'b1;
            if (!lat_we) d_rdata <= mem_rdata;
          end
        end else begin
          acc_cnt <= acc_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned STR0 = 4;
  localparam int unsigned LAT1 = 3;
  localparam int unsigned STR1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        if_req[2];
  logic        d_req[2];
  logic        d_we[2];
  logic [31:0] if_addr[2];
  logic [31:0] d_addr[2];
  logic [31:0] d_wdata[2];
  logic [31:0] mem_rdata[2];
  logic [3:0]  d_sel[2];
  logic        if_ack[2];
  logic        d_ack[2];
  logic        mem_ce[2];
  logic        mem_we[2];
  logic        stall_req[2];
  logic [31:0] if_rdata[2];
  logic [31:0] d_rdata[2];
  logic [31:0] mem_addr[2];
  logic [31:0] mem_wdata[2];
  logic [3:0]  mem_sel[2];

  mem_arbiter #(.LAT(LAT0), .STREAK(STR0)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_sel(d_sel[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_ce(mem_ce[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_sel(mem_sel[0]), .mem_rdata(mem_rdata[0]), .stall_req(stall_req[0])
  );

  mem_arbiter #(.LAT(LAT1), .STREAK(STR1)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_sel(d_sel[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_ce(mem_ce[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_sel(mem_sel[1]), .mem_rdata(mem_rdata[1]), .stall_req(stall_req[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, then check the invariants
  // that hold in every cycle: one-hot acks and a quiet memory bus when idle.
  task automatic step();
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("ack_onehot", 32'(if_ack[u] & d_ack[u]), 32'h0);
      if (!mem_ce[u])
        chk("mem_idle_zero", 32'(mem_we[u]) | mem_addr[u] | mem_wdata[u] | 32'(mem_sel[u]), 32'h0);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks who owns the memory and how many access cycles remain.
  int          m_own[2];      // 0 none, 1 fetch, 2 data
  int          m_left[2];
  int          m_streak[2];
  logic        m_ia[2];
  logic        m_da[2];
  logic        m_mwe[2];
  logic [31:0] m_ird[2];
  logic [31:0] m_drd[2];
  logic [31:0] m_maddr[2];
  logic [31:0] m_mwdata[2];
  logic [3:0]  m_msel[2];

  function automatic int lat_of(input int u);
    return (u == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic int str_of(input int u);
    return (u == 0) ? int'(STR0) : int'(STR1);
  endfunction

  task automatic model_reset(input int u);
    m_own[u] = 0; m_left[u] = 0; m_streak[u] = 0;
    m_ia[u] = 1'b0; m_da[u] = 1'b0; m_mwe[u] = 1'b0;
    m_ird[u] = '0; m_drd[u] = '0; m_maddr[u] = '0; m_mwdata[u] = '0; m_msel[u] = '0;
  endtask

  task automatic model_step(input int u);
    logic fp, dp, nia, nda;
    if (rst[u]) begin
      model_reset(u);
    end else begin
      nia = 1'b0;
      nda = 1'b0;
      if (m_own[u] != 0) begin
        m_left[u]--;
        if (m_left[u] == 0) begin
          if (m_own[u] == 1) begin
            nia = 1'b1;
            m_ird[u] = mem_rdata[u];
          end else begin
            nda = 1'b1;
            if (!m_mwe[u]) m_drd[u] = mem_rdata[u];
          end
          m_own[u] = 0;
        end
      end else begin
        fp = if_req[u] && !m_ia[u];
        dp = d_req[u] && !m_da[u];
        if (dp && !(fp && m_streak[u] == str_of(u))) begin
          m_own[u] = 2; m_left[u] = lat_of(u);
          m_mwe[u] = d_we[u]; m_maddr[u] = d_addr[u]; m_mwdata[u] = d_wdata[u]; m_msel[u] = d_sel[u];
          if (fp) m_streak[u] = (m_streak[u] < str_of(u)) ? m_streak[u] + 1 : m_streak[u];
          else    m_streak[u] = 0;
        end else if (fp) begin
          m_own[u] = 1; m_left[u] = lat_of(u);
          m_mwe[u] = 1'b0; m_maddr[u] = if_addr[u]; m_mwdata[u] = '0; m_msel[u] = 4'hF;
          m_streak[u] = 0;
        end
      end
      m_ia[u] = nia;
      m_da[u] = nda;
    end
  endtask

  task automatic model_compare(input int u);
    logic busy;
    busy = (m_own[u] != 0);
    chk("rnd_mem_ce",    32'(mem_ce[u]),  32'(busy));
    chk("rnd_mem_we",    32'(mem_we[u]),  busy ? 32'(m_mwe[u]) : 32'h0);
    chk("rnd_mem_addr",  mem_addr[u],     busy ? m_maddr[u] : 32'h0);
    chk("rnd_mem_wdata", mem_wdata[u],    busy ? m_mwdata[u] : 32'h0);
    chk("rnd_mem_sel",   32'(mem_sel[u]), busy ? 32'(m_msel[u]) : 32'h0);
    chk("rnd_if_ack",    32'(if_ack[u]),  32'(m_ia[u]));
    chk("rnd_d_ack",     32'(d_ack[u]),   32'(m_da[u]));
    chk("rnd_if_rdata",  if_rdata[u],     m_ird[u]);
    chk("rnd_d_rdata",   d_rdata[u],      m_drd[u]);
  endtask

  task automatic drive_random(input int u);
    if (if_req[u] && if_ack[u]) begin
      if ($urandom_range(1, 0) == 1) if_addr[u] = $urandom;
      else if_req[u] = 1'b0;
    end else if (!if_req[u] && $urandom_range(3, 0) == 0) begin
      if_req[u] = 1'b1;
      if_addr[u] = $urandom;
    end
    if (d_req[u] && d_ack[u]) begin
      if ($urandom_range(1, 0) == 1) begin
        d_we[u] = 1'($urandom_range(1, 0)); d_addr[u] = $urandom;
        d_wdata[u] = $urandom; d_sel[u] = 4'($urandom);
      end else d_req[u] = 1'b0;
    end else if (!d_req[u] && $urandom_range(2, 0) == 0) begin
      d_req[u] = 1'b1;
      d_we[u] = 1'($urandom_range(1, 0)); d_addr[u] = $urandom;
      d_wdata[u] = $urandom; d_sel[u] = 4'($urandom);
    end
    // Occasional input churn; anything already latched must not follow it.
    if ($urandom_range(7, 0) == 0) begin
      d_we[u] = 1'($urandom_range(1, 0)); d_addr[u] = $urandom;
      d_wdata[u] = $urandom; d_sel[u] = 4'($urandom); if_addr[u] = $urandom;
    end
    mem_rdata[u] = $urandom;
    rst[u] = ($urandom_range(63, 0) == 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] mem_rd;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  int   nd, ni, nd_after;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h3401_1100, 1'b0, 4'hF, 32'h0, 32'h3401_1100, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h1234_5678, 32'h3401_1100, 32'hCAFE_F00D};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'h3, 32'h1111_1111, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h3401_1100, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0, 32'hFFFF_FFFF, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h8, 32'h0000_0000, 1'b0, 4'h8, 32'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 32'h1000_0004, 32'h0BAD_F00D, 4'hC, 32'h7777_7777, 1'b1, 4'hC, 32'h0BAD_F00D, 32'hFFFF_FFFF, 32'h0};

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; if_req[u] = 1'b0; d_req[u] = 1'b0; d_we[u] = 1'b0;
      if_addr[u] = '0; d_addr[u] = '0; d_wdata[u] = '0; d_sel[u] = '0; mem_rdata[u] = '0;
    end

    // Reset state
    step();
    step();
    for (int u = 0; u < 2; u++) begin
      chk("rst_if_ack",   32'(if_ack[u]), 32'h0);
      chk("rst_d_ack",    32'(d_ack[u]),  32'h0);
      chk("rst_if_rdata", if_rdata[u],    32'h0);
      chk("rst_d_rdata",  d_rdata[u],     32'h0);
      chk("rst_mem_ce",   32'(mem_ce[u]), 32'h0);
      chk("rst_stall",    32'(stall_req[u]), 32'h0);
      rst[u] = 1'b0;
    end
    step();

    // Isolated transactions on the LAT=1 instance
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      if_req[0]  = v.fetch;
      if_addr[0] = v.fetch ? v.addr : 32'hBAD0_0000;
      d_req[0]   = !v.fetch;
      d_we[0]    = v.fetch ? 1'b1 : v.we;
      d_addr[0]  = v.fetch ? 32'hBAD1_0000 : v.addr;
      d_wdata[0] = v.fetch ? 32'hFFFF_0000 : v.wdata;
      d_sel[0]   = v.fetch ? 4'h5 : v.sel;
      mem_rdata[0] = v.mem_rd;
      #1;
      chk("vec_stall_req_cycle", 32'(stall_req[0]), 32'h1);
      chk("vec_ce_req_cycle",    32'(mem_ce[0]),    32'h0);
      for (int k = 0; k < int'(LAT0); k++) begin
        step();
        chk("vec_acc_ce",    32'(mem_ce[0]),  32'h1);
        chk("vec_acc_addr",  mem_addr[0],     v.addr);
        chk("vec_acc_we",    32'(mem_we[0]),  32'(v.exp_we));
        chk("vec_acc_sel",   32'(mem_sel[0]), 32'(v.exp_sel));
        chk("vec_acc_wdata", mem_wdata[0],    v.exp_wdata);
        chk("vec_acc_noack", 32'(if_ack[0] | d_ack[0]), 32'h0);
        chk("vec_acc_stall", 32'(stall_req[0]), 32'h1);
      end
      step();
      chk("vec_if_ack",     32'(if_ack[0]), 32'(v.fetch));
      chk("vec_d_ack",      32'(d_ack[0]),  32'(!v.fetch));
      chk("vec_ack_ce",     32'(mem_ce[0]), 32'h0);
      chk("vec_if_rdata",   if_rdata[0],    v.exp_if);
      chk("vec_d_rdata",    d_rdata[0],     v.exp_d);
      chk("vec_ack_stall",  32'(stall_req[0]), 32'h0);
      if_req[0] = 1'b0;
      d_req[0]  = 1'b0;
      step();
      chk("vec_ack_pulse",  32'(if_ack[0] | d_ack[0]), 32'h0);
      chk("vec_if_hold",    if_rdata[0], v.exp_if);
      chk("vec_d_hold",     d_rdata[0],  v.exp_d);
    end

    // Simultaneous requests: data first, then fetch
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_0040;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_0100; d_sel[0] = 4'hF;
    mem_rdata[0] = 32'h5555_AAAA;
    step();
    chk("both_first_addr", mem_addr[0], 32'h0000_0100);
    chk("both_first_we",   32'(mem_we[0]), 32'h0);
    step();
    chk("both_d_ack",    32'(d_ack[0]),  32'h1);
    chk("both_d_rdata",  d_rdata[0],     32'h5555_AAAA);
    chk("both_if_wait",  32'(if_ack[0]), 32'h0);
    chk("both_stall",    32'(stall_req[0]), 32'h1);
    d_req[0] = 1'b0;
    mem_rdata[0] = 32'h2400_0001;
    step();
    chk("both_second_ce",   32'(mem_ce[0]), 32'h1);
    chk("both_second_addr", mem_addr[0],    32'h0000_0040);
    step();
    chk("both_if_ack",    32'(if_ack[0]), 32'h1);
    chk("both_if_rdata",  if_rdata[0],    32'h2400_0001);
    if_req[0] = 1'b0;
    step();

    // Data streak: d_req held high, fetch presented at every arbitration slot
    nd = 0; ni = 0; nd_after = 0;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0000_1000;
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_0800;
    for (int c = 0; c < 40; c++) begin
      step();
      if (d_ack[0]) begin
        if (ni == 0) nd++;
        else nd_after++;
        d_addr[0] = d_addr[0] + 32'd4;
      end
      if (if_ack[0]) ni++;
      if_req[0] = (ni == 0) && !d_ack[0];
      if (nd_after != 0) break;
    end
    chk("streak_d_acks_before_fetch", 32'(nd), 32'(STR0));
    chk("streak_fetch_acks", 32'(ni), 32'h1);
    chk("streak_data_resumes", 32'(nd_after != 0), 32'h1);
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    step();
    step();

    // Reset in the second cycle of a LAT=3 fetch
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_0080; mem_rdata[1] = 32'h0F0F_0F0F;
    step();
    chk("rstacc_c1_ce", 32'(mem_ce[1]), 32'h1);
    chk("rstacc_c1_addr", mem_addr[1], 32'h0000_0080);
    step();
    chk("rstacc_c2_ce", 32'(mem_ce[1]), 32'h1);
    rst[1] = 1'b1;
    step();
    chk("rstacc_abort_ce", 32'(mem_ce[1]), 32'h0);
    chk("rstacc_abort_ack", 32'(if_ack[1]), 32'h0);
    chk("rstacc_abort_rdata", if_rdata[1], 32'h0);
    rst[1] = 1'b0;
    mem_rdata[1] = 32'hA5A5_A5A5;
    for (int k = 0; k < int'(LAT1); k++) begin
      step();
      chk("rstacc_retry_ce", 32'(mem_ce[1]), 32'h1);
      chk("rstacc_retry_noack", 32'(if_ack[1]), 32'h0);
    end
    step();
    chk("rstacc_retry_ack", 32'(if_ack[1]), 32'h1);
    chk("rstacc_retry_rdata", if_rdata[1], 32'hA5A5_A5A5);
    if_req[1] = 1'b0;
    step();

    // Randomized traffic on both instances against the reference model
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; if_req[u] = 1'b0; d_req[u] = 1'b0;
      model_reset(u);
    end
    step();
    for (int u = 0; u < 2; u++) rst[u] = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int u = 0; u < 2; u++) model_compare(u);
      for (int u = 0; u < 2; u++) drive_random(u);
      #1;
      for (int u = 0; u < 2; u++)
        chk("rnd_stall", 32'(stall_req[u]),
            32'((if_req[u] & ~m_ia[u]) | (d_req[u] & ~m_da[u])));
      for (int u = 0; u < 2; u++) model_step(u);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
